mips_multicycle_ctrl: RTL

- Control FSM that sequences a shared-memory multicycle MIPS datapath: one ALU, one unified memory and an instruction register, reused across the steps of each instruction.
- Drives every datapath mux, enable and ALU control from the current state and the decoded opcode/funct.
- Stalls on a memory-ready handshake.
- Traps on unsupported encodings.

---
 rtl/mips_multicycle_ctrl_if.sv | 36 +++
 rtl/mips_multicycle_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl_if.sv
// Datapath-facing bundle for the multicycle MIPS control FSM: decoded instruction
// fields and status flags in, datapath mux selects and enables out.
interface mips_multicycle_ctrl_if;
   logic [5:0] i_op_w;
   logic [5:0] i_funct_w;
   logic       i_zero_w;
   logic       i_mem_ready_w;
   logic       o_pc_write_w;
   logic       o_iord_w;
   logic       o_mem_write_w;
   logic       o_mem_read_w;
   logic       o_ir_write_w;
   logic       o_reg_dst_w;
   logic       o_mem_to_reg_w;
   logic       o_reg_write_w;
   logic       o_alu_src_a_w;
   logic [1:0] o_alu_src_b_w;
   logic [1:0] o_pc_src_w;
   logic [2:0] o_alu_control_w;
   logic [3:0] o_state_w;
   logic       o_illegal_w;

   modport slave (
      input  i_op_w, i_funct_w, i_zero_w, i_mem_ready_w,
      output o_pc_write_w, o_iord_w, o_mem_write_w, o_mem_read_w, o_ir_write_w,
             o_reg_dst_w, o_mem_to_reg_w, o_reg_write_w, o_alu_src_a_w,
             o_alu_src_b_w, o_pc_src_w, o_alu_control_w, o_state_w, o_illegal_w
   );

   modport master (
      output i_op_w, i_funct_w, i_zero_w, i_mem_ready_w,
      input  o_pc_write_w, o_iord_w, o_mem_write_w, o_mem_read_w, o_ir_write_w,
             o_reg_dst_w, o_mem_to_reg_w, o_reg_write_w, o_alu_src_a_w,
             o_alu_src_b_w, o_pc_src_w, o_alu_control_w, o_state_w, o_illegal_w
   );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared ALU and unified memory, stalling on the memory-ready handshake.
module mips_multicycle_ctrl #(
   parameter bit ILLEGAL_TRAP = 1'b1
) (
   input logic                   i_clk_w,
   input logic                   i_rst_w,
   mips_multicycle_ctrl_if.slave bus
);

   localparam int unsigned STATE_W = 4;
   localparam int unsigned ALU_W   = 3;

   localparam logic [STATE_W-1:0] S_FETCH  = 4'd0;
   localparam logic [STATE_W-1:0] S_DECODE = 4'd1;
   localparam logic [STATE_W-1:0] S_MEMADR = 4'd2;
   localparam logic [STATE_W-1:0] S_MEMRD  = 4'd3;
   localparam logic [STATE_W-1:0] S_MEMWB  = 4'd4;
   localparam logic [STATE_W-1:0] S_MEMWR  = 4'd5;
   localparam logic [STATE_W-1:0] S_EXEC   = 4'd6;
   localparam logic [STATE_W-1:0] S_ALUWB  = 4'd7;
   localparam logic [STATE_W-1:0] S_BRANCH = 4'd8;
   localparam logic [STATE_W-1:0] S_ADDIEX = 4'd9;
   localparam logic [STATE_W-1:0] S_ADDIWB = 4'd10;
   localparam logic [STATE_W-1:0] S_JUMP   = 4'd11;
   localparam logic [STATE_W-1:0] S_TRAP   = 4'd15;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
   localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
   localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
   localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
   localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

   localparam logic [STATE_W-1:0] S_BAD = ILLEGAL_TRAP ? S_TRAP : S_FETCH;

   logic [STATE_W-1:0] state;
   logic [STATE_W-1:0] state_nx;
   logic               funct_ok_c;
   logic [ALU_W-1:0]   funct_alu_c;
   logic               ready;

   logic               pc_write_c, iord_c, mem_write_c, mem_read_c, ir_write_c;
   logic               reg_dst_c, mem_to_reg_c, reg_write_c, src_a_c;
   logic [1:0]         src_b_c, pc_src_c;
   logic [ALU_W-1:0]   alu_c;

   assign ready = bus.i_mem_ready_w;

   // R-type funct to ALU operation; unsupported funct falls back to add
   always_comb begin
      funct_ok_c  = 1'b1;
      funct_alu_c = ALU_ADD;
      case (bus.i_funct_w)
         6'b100000: funct_alu_c = ALU_ADD;
         6'b100010: funct_alu_c = ALU_SUB;
         6'b100100: funct_alu_c = ALU_AND;
         6'b100101: funct_alu_c = ALU_OR;
         6'b101010: funct_alu_c = ALU_SLT;
         default:   funct_ok_c  = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk_w or negedge i_rst_w) begin
      if (!i_rst_w) state <= S_FETCH;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH:  if (ready) state_nx = S_DECODE;
         S_DECODE: begin
            case (bus.i_op_w)
               OP_LW, OP_SW: state_nx = S_MEMADR;
               OP_RTYPE:     state_nx = S_EXEC;
               OP_BEQ:       state_nx = S_BRANCH;
               OP_ADDI:      state_nx = S_ADDIEX;
               OP_J:         state_nx = S_JUMP;
               default:      state_nx = S_BAD;
            endcase
         end
         S_MEMADR: state_nx = (bus.i_op_w == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  if (ready) state_nx = S_MEMWB;
         S_MEMWR:  if (ready) state_nx = S_FETCH;
         S_EXEC:   state_nx = funct_ok_c ? S_ALUWB : S_BAD;
         S_ADDIEX: state_nx = S_ADDIWB;
         S_TRAP:   state_nx = S_TRAP;
         default:  state_nx = S_FETCH;
      endcase
   end

   // State-decoded datapath controls; PC/IR enables also follow zero and ready
   always_comb begin
      pc_write_c   = 1'b0;
      iord_c       = 1'b0;
      mem_write_c  = 1'b0;
      mem_read_c   = 1'b0;
      ir_write_c   = 1'b0;
      reg_dst_c    = 1'b0;
      mem_to_reg_c = 1'b0;
      reg_write_c  = 1'b0;
      src_a_c      = 1'b0;
      src_b_c      = 2'b00;
      pc_src_c     = 2'b00;
      alu_c        = ALU_ADD;
      case (state)
         S_FETCH: begin
            mem_read_c = 1'b1;
            src_b_c    = 2'b01;
            ir_write_c = ready;
            pc_write_c = ready;
         end
         S_DECODE: src_b_c = 2'b11;
         S_MEMADR: begin
            src_a_c = 1'b1;
            src_b_c = 2'b10;
         end
         S_MEMRD: begin
            mem_read_c = 1'b1;
            iord_c     = 1'b1;
         end
         S_MEMWB: begin
            reg_write_c  = 1'b1;
            mem_to_reg_c = 1'b1;
         end
         S_MEMWR: begin
            iord_c      = 1'b1;
            mem_write_c = 1'b1;
         end
         S_EXEC: begin
            src_a_c = 1'b1;
            alu_c   = funct_alu_c;
         end
         S_ALUWB: begin
            reg_write_c = 1'b1;
            reg_dst_c   = 1'b1;
         end
         S_BRANCH: begin
            src_a_c    = 1'b1;
            alu_c      = ALU_SUB;
            pc_src_c   = 2'b01;
            pc_write_c = bus.i_zero_w;
         end
         S_ADDIEX: begin
            src_a_c = 1'b1;
            src_b_c = 2'b10;
         end
         S_ADDIWB: reg_write_c = 1'b1;
         S_JUMP: begin
            pc_src_c   = 2'b10;
            pc_write_c = 1'b1;
         end
         default: alu_c = ALU_ADD;
      endcase
   end

   // Reset blanks every control immediately, not just from the next edge
   assign bus.o_pc_write_w    = i_rst_w & pc_write_c;
   assign bus.o_iord_w        = i_rst_w & iord_c;
   assign bus.o_mem_write_w   = i_rst_w & mem_write_c;
   assign bus.o_mem_read_w    = i_rst_w & mem_read_c;
   assign bus.o_ir_write_w    = i_rst_w & ir_write_c;
   assign bus.o_reg_dst_w     = i_rst_w & reg_dst_c;
   assign bus.o_mem_to_reg_w  = i_rst_w & mem_to_reg_c;
   assign bus.o_reg_write_w   = i_rst_w & reg_write_c;
   assign bus.o_alu_src_a_w   = i_rst_w & src_a_c;
   assign bus.o_alu_src_b_w   = i_rst_w ? src_b_c : 2'b00;
   assign bus.o_pc_src_w      = i_rst_w ? pc_src_c : 2'b00;
   assign bus.o_alu_control_w = i_rst_w ? alu_c : 3'b000;
   assign bus.o_state_w       = state;
   assign bus.o_illegal_w     = i_rst_w & (state == S_TRAP);

endmodule
